sweep_ctrl: RTL and testbench
=============================

SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter Width, default 8: bit width of the voltage code.
REQ-002 Parameter LastCode, default 8'd255: final code of the sweep.
REQ-003 Parameter SettleCycles, default 16: DAC settling wait, in clk_i cycles; legal range is 1 or more.
REQ-004 Parameter TimeoutCycles, default 65535: handshake watchdog limit; used only when the timeout feature is compiled in.
REQ-005 clk_i  in  1  single clock; every register is clocked on its rising edge.
REQ-006 rst_i  in  1  reset; synchronous and active-high.
REQ-007 start_i  in  1  level; begins a sweep when sampled high in IDLE.
REQ-008 abort_i  in  1  synchronous abort of a sweep in progress.
REQ-009 count_i  in  Width  current code from the downstream voltage counter.
REQ-010 dac_done_i, adc_done_i, tx_done_i  in  1 each  one-cycle completion strobes.
REQ-011 opc1_o  out  2  counter opcode: 00 = clear, 01 = hold, 10 = increment.
REQ-012 dac_start_o, adc_start_o, tx_start_o  out  1 each  one-cycle start strobes.
REQ-013 busy_o  out  1  high in every state except IDLE.
REQ-014 done_o  out  1  one-cycle strobe at the end of a sweep.
REQ-015 error_o  out  1  sticky handshake-timeout flag.

Function
REQ-016 Moore FSM with states IDLE, CLEAR, DAC_ST, DAC_WT, SETTLE, ADC_ST, ADC_WT, TX_ST, TX_WT, CHECK, STEP, FIN, ERR; all outputs SHALL decode from registered state only.
REQ-017 opc1_o SHALL be 00 in CLEAR, 10 in STEP, and 01 in every other state.
REQ-018 Strobes SHALL be high only in their state: dac_start_o in DAC_ST, adc_start_o in ADC_ST, tx_start_o in TX_ST, done_o in FIN.
REQ-019 IDLE SHALL go to CLEAR on start_i = 1; otherwise it SHALL stay in IDLE.
REQ-020 CLEAR, DAC_ST, ADC_ST, TX_ST, STEP and FIN SHALL each last exactly one cycle.
REQ-021 Unconditional transitions: CLEAR to DAC_ST; STEP to DAC_ST; FIN to IDLE.
REQ-022 Start-state transitions: DAC_ST to DAC_WT; ADC_ST to ADC_WT; TX_ST to TX_WT.
REQ-023 DAC_WT SHALL go to SETTLE on dac_done_i; ADC_WT to TX_ST on adc_done_i; TX_WT to CHECK on tx_done_i.
REQ-024 A done input asserted in DAC_ST, ADC_ST or TX_ST SHALL be ignored; a done input SHALL also be ignored outside its own WT state.
REQ-025 SETTLE SHALL last exactly SettleCycles cycles, using an internal down-counter loaded on entry, then go to ADC_ST.
REQ-026 CHECK SHALL go to FIN when count_i == LastCode, otherwise to STEP; the comparison is unsigned and full-width.
REQ-027 The code used by each conversion is the value the counter holds during DAC_ST, which SHALL be one greater than in the previous point (0 after CLEAR).
REQ-028 A sweep SHALL produce exactly LastCode+1 DAC/ADC/TX triplets; there is no wrap-around past LastCode.
REQ-029 start_i SHALL be ignored in every state except IDLE.
REQ-030 abort_i SHALL force IDLE on the next edge from any state, with no done_o; abort_i takes priority over every other transition.
REQ-031 If start_i and abort_i are high together in IDLE, the FSM SHALL remain in IDLE.

Reset
REQ-032 When rst_i is sampled high, the FSM SHALL go to IDLE and the settle and timeout counters and error_o SHALL clear to 0.
REQ-033 Output values after reset: opc1_o = 01; every strobe, busy_o, done_o and error_o = 0.
REQ-034 Reset mid-sweep SHALL terminate the sweep with no strobe on the following cycle.
REQ-035 rst_i SHALL take priority over abort_i and start_i.

Configuration
REQ-036 Macro SWEEP_CTRL_TIMEOUT_EN.
REQ-037 When the macro is defined, a counter SHALL run in DAC_WT, ADC_WT and TX_WT and clear on entry to each of those states.
REQ-038 When the macro is defined and that counter reaches TimeoutCycles, the FSM SHALL go to ERR; ERR sets error_o and lasts one cycle, then goes to IDLE.
REQ-039 When the macro is defined, error_o SHALL remain high until the next accepted start_i, which clears it when the FSM enters CLEAR.
REQ-040 When the macro is undefined, the WT states SHALL wait indefinitely, error_o SHALL be tied to 0, and no timeout counter is built.

Verification
REQ-041 Parameters LastCode = 3 and SettleCycles = 4, with a counter model and every done strobe returned 2 cycles after its start: a 1-cycle start_i SHALL produce dac_start_o with the counter at codes 0, 1, 2 and 3, then one done_o, with opc1_o = 10 exactly 3 times.
REQ-042 Measure dac_done_i to adc_start_o: the interval SHALL be exactly 5 cycles (4 SETTLE cycles plus 1).
REQ-043 Pulse adc_done_i during DAC_WT: the FSM SHALL stay in DAC_WT and no adc_start_o SHALL appear early.
REQ-044 Assert abort_i during SETTLE: busy_o SHALL be 0 on the next cycle, with no done_o; a new start_i SHALL then sweep from code 0.
REQ-045 Assert rst_i during TX_WT: on the next cycle opc1_o = 01, busy_o = 0, and all strobes are 0.
REQ-046 With SWEEP_CTRL_TIMEOUT_EN defined, TimeoutCycles = 10 and tx_done_i withheld: error_o SHALL rise after 10 cycles in TX_WT and then busy_o = 0; error_o SHALL clear on the next start.

Source files
------------

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: DAC/ADC/TX sequencer that sweeps the code counter 0..LastCode.
// Define SWEEP_CTRL_TIMEOUT_EN to build the handshake watchdog and error_o.
module sweep_ctrl #(
  parameter int               Width         = 8,
  parameter logic [Width-1:0] LastCode      = 8'd255,
  parameter int               SettleCycles  = 16,
  parameter int               TimeoutCycles = 65535
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [Width-1:0] count_i,
  input  logic             dac_done_i,
  input  logic             adc_done_i,
  input  logic             tx_done_i,
  output logic [1:0]       opc1_o,
  output logic             dac_start_o,
  output logic             adc_start_o,
  output logic             tx_start_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, DAC_ST, DAC_WT, SETTLE, ADC_ST, ADC_WT,
    TX_ST, TX_WT, CHECK, STEP, FIN, ERR
  } state_e;

  localparam int            SW        = $clog2(SettleCycles + 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SettleCycles - 1);

  if (SettleCycles < 1 || TimeoutCycles < 1) begin : g_bad_param
    $error("sweep_ctrl: SettleCycles and TimeoutCycles must be >= 1");
  end

  state_e        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          tmo_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      IDLE:   if (start_i) state_d = CLEAR;
      CLEAR:  state_d = DAC_ST;
      DAC_ST: state_d = DAC_WT;
      DAC_WT: begin
        if (dac_done_i) begin
          state_d  = SETTLE;
          settle_d = SETTLE_LD;
        end else if (tmo_hit) begin
          state_d = ERR;
        end
      end
      // settle_q counts SettleCycles-1 down to 0, one cycle per value
      SETTLE: begin
        if (settle_q == '0) state_d = ADC_ST;
        else settle_d = settle_q - 1'b1;
      end
      ADC_ST: state_d = ADC_WT;
      ADC_WT: begin
        if (adc_done_i) state_d = TX_ST;
        else if (tmo_hit) state_d = ERR;
      end
      TX_ST:  state_d = TX_WT;
      TX_WT: begin
        if (tx_done_i) state_d = CHECK;
        else if (tmo_hit) state_d = ERR;
      end
      CHECK:  state_d = (count_i == LastCode) ? FIN : STEP;
      STEP:   state_d = DAC_ST;
      FIN:    state_d = IDLE;
      ERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

`ifdef SWEEP_CTRL_TIMEOUT_EN
  localparam int            TW       = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TimeoutCycles - 1);

  logic [TW-1:0] tmo_q;
  logic          error_q;
  logic          in_wt;

  assign in_wt   = state_q inside {DAC_WT, ADC_WT, TX_WT};
  assign tmo_hit = in_wt && (tmo_q == TMO_LAST);

  // tmo_q rests at 0 outside the wait states, so each entry starts fresh
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q   <= '0;
      error_q <= 1'b0;
    end else begin
      tmo_q <= in_wt ? tmo_q + 1'b1 : '0;
      if (state_d == ERR) error_q <= 1'b1;
      else if (state_d == CLEAR) error_q <= 1'b0;
    end
  end

  assign error_o = error_q;
`else
  assign tmo_hit = 1'b0;
  assign error_o = 1'b0;
`endif

  assign opc1_o      = (state_q == CLEAR) ? 2'b00 :
                       (state_q == STEP)  ? 2'b10 : 2'b01;
  assign dac_start_o = (state_q == DAC_ST);
  assign adc_start_o = (state_q == ADC_ST);
  assign tx_start_o  = (state_q == TX_ST);
  assign done_o      = (state_q == FIN);
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: scoreboard bench for sweep_ctrl, LastCode=3, SettleCycles=4.
// Counter model plus auto-responder returning each done 2 cycles after start.
module tb_sweep_ctrl;

  typedef struct packed {
    logic       is_done;
    logic [7:0] code;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [7:0] count_i;
  logic       dac_done_i, adc_done_i, tx_done_i;
  logic [1:0] opc1_o;
  logic       dac_start_o, adc_start_o, tx_start_o;
  logic       busy_o, done_o, error_o;

  logic       dac_r = 0, adc_r = 0, tx_r = 0, inj_adc = 0, hold_tx = 0;
  logic [1:0] dp = '0, ap = '0, tp = '0;
  logic [7:0] cnt_m = 8'h55;
  int         cyc = 0, dd_cyc = 0, steps = 0;
  int         vectors = 0, errors = 0;
  exp_t       sb[$];

  assign count_i    = cnt_m;
  assign dac_done_i = dac_r;
  assign adc_done_i = adc_r | inj_adc;
  assign tx_done_i  = tx_r;

  sweep_ctrl #(
    .Width(8), .LastCode(8'd3), .SettleCycles(4), .TimeoutCycles(10)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .count_i(count_i), .dac_done_i(dac_done_i), .adc_done_i(adc_done_i),
    .tx_done_i(tx_done_i), .opc1_o(opc1_o), .dac_start_o(dac_start_o),
    .adc_start_o(adc_start_o), .tx_start_o(tx_start_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // downstream voltage counter driven by opc1_o
  always @(posedge clk)
    case (opc1_o)
      2'b00:   cnt_m <= 8'd0;
      2'b10:   cnt_m <= cnt_m + 8'd1;
      default: cnt_m <= cnt_m;
    endcase

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // responder: done strobe in the 2nd cycle after its start strobe
  initial forever begin
    @(posedge clk);
    #2;
    dac_r = dp[1]; dp = {dp[0], dac_start_o};
    adc_r = ap[1]; ap = {ap[0], adc_start_o};
    tx_r  = tp[1] & ~hold_tx; tp = {tp[0], tx_start_o};
    if (dac_r) dd_cyc = cyc;
  end

  // monitor: pops the scoreboard on every dac_start_o / done_o
  initial forever begin
    exp_t e;
    tick();
    if (opc1_o == 2'b10) steps++;
    if (dac_start_o || done_o) begin
      if (sb.size() == 0) begin
        chk(dac_start_o ? "unexpected_dac_start" : "unexpected_done",
            1, 0);
      end else begin
        e = sb.pop_front();
        chk("event_kind_done", int'(done_o), int'(e.is_done));
        if (dac_start_o) chk("dac_code", int'(count_i), int'(e.code));
      end
    end
    if (adc_start_o) chk("dac_done_to_adc_start", cyc - dd_cyc, 5);
  end

  task automatic push_sweep(input int last);
    for (int c = 0; c <= last; c++) sb.push_back('{1'b0, 8'(c)});
    sb.push_back('{1'b1, 8'd0});
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!busy_o) return;
    end
    chk({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic wait_strobe(input int which, input string name);
    for (int i = 0; i < 200; i++) begin
      tick();
      if ((which == 0 && dac_start_o) || (which == 2 && tx_start_o)) return;
    end
    chk({name, "_strobe_timeout"}, 1, 0);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_opc"}, int'(opc1_o), 1);
    chk({name, "_busy"}, int'(busy_o), 0);
    chk({name, "_strobes"},
        int'({dac_start_o, adc_start_o, tx_start_o, done_o}), 0);
    chk({name, "_error"}, int'(error_o), 0);
  endtask

  initial begin
    repeat (3) tick();
    chk_quiet("reset");
    rst_i = 1'b0;
    tick();
    chk_quiet("idle");

    // full sweep: codes 0..3, one done, three increments
    steps = 0;
    push_sweep(3);
    start_pulse();
    chk("clear_opc", int'(opc1_o), 0);
    wait_idle("sweep1");
    chk("step_count", steps, 3);
    chk("sb_empty_sweep1", sb.size(), 0);

    // start and abort together in IDLE: stays idle
    start_i = 1'b1; abort_i = 1'b1;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    chk("start_abort_busy", int'(busy_o), 0);

    // adc_done_i during DAC_WT is ignored
    push_sweep(3);
    start_pulse();
    wait_strobe(0, "adc_inj");
    tick();
    inj_adc = 1'b1;
    tick();
    inj_adc = 1'b0;
    chk("no_early_adc_start", int'(adc_start_o), 0);
    wait_idle("sweep2");
    chk("sb_empty_sweep2", sb.size(), 0);

    // abort in SETTLE of the second point, then sweep again from 0
    sb.push_back('{1'b0, 8'd0});
    sb.push_back('{1'b0, 8'd1});
    start_pulse();
    wait_strobe(0, "abort_p0");
    wait_strobe(0, "abort_p1");
    repeat (4) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_done", int'(done_o), 0);
    repeat (10) tick();
    chk("sb_empty_abort", sb.size(), 0);
    push_sweep(3);
    start_pulse();
    wait_strobe(0, "restart");
    repeat (2) tick();
    start_pulse();
    wait_idle("sweep3");
    chk("sb_empty_sweep3", sb.size(), 0);

    // reset during TX_WT
    sb.push_back('{1'b0, 8'd0});
    start_pulse();
    wait_strobe(2, "rst_tx");
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_quiet("rst_in_tx_wt");
    repeat (5) tick();
    chk("sb_empty_rst", sb.size(), 0);

`ifdef SWEEP_CTRL_TIMEOUT_EN
    // withheld tx_done_i: ERR after 10 cycles in TX_WT
    sb.push_back('{1'b0, 8'd0});
    hold_tx = 1'b1;
    start_pulse();
    wait_strobe(2, "tmo");
    repeat (10) tick();
    chk("tmo_err_early", int'(error_o), 0);
    chk("tmo_busy_wt", int'(busy_o), 1);
    tick();
    chk("tmo_err_set", int'(error_o), 1);
    tick();
    chk("tmo_busy_after", int'(busy_o), 0);
    chk("tmo_err_sticky", int'(error_o), 1);
    hold_tx = 1'b0;
    repeat (3) tick();
    push_sweep(3);
    start_pulse();
    chk("tmo_err_clear", int'(error_o), 0);
    wait_idle("sweep_tmo");
    chk("sb_empty_tmo", sb.size(), 0);
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
